// File: rtl/mips_imem_ctrl.sv
// Instruction memory controller: boot-load from a host port, then serve fetches.
// Optional macro IMEM_BOUND_CHECK_EN: fault fetches beyond the loaded word count.
module mips_imem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              loading,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_pc,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_RUN_IDLE,
        S_RUN_WAIT,
        S_RUN_RESP
    } state_t;

    localparam logic [ADDR_W-1:0] WPTR_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;
    logic [DATA_W-1:0] cpu_instr_q, cpu_instr_d;
    logic              cpu_fault_q, cpu_fault_d;
    logic              out_of_range;

    // Fetch range check: beyond the array, optionally beyond the loaded image.
    always_comb begin
        out_of_range = |cpu_pc[31:ADDR_W];
`ifdef IMEM_BOUND_CHECK_EN
        if (cpu_pc >= 32'(ld_count_q)) begin
            out_of_range = 1'b1;
        end
`endif
    end

    // Next-state, loader write path and fetch response logic.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        ld_count_d  = ld_count_q;
        cpu_instr_d = cpu_instr_q;
        cpu_fault_d = cpu_fault_q;
        ld_ready    = 1'b0;
        loading     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = cpu_pc[ADDR_W-1:0];
        mem_wdata   = ld_data;
        unique case (state_q)
            S_LOAD: begin
                ld_ready = !reset;
                loading  = 1'b1;
                mem_addr = wptr_q;
                if (ld_valid && !reset) begin
                    mem_we     = 1'b1;
                    wptr_d     = wptr_q + ADDR_W'(1);
                    ld_count_d = ld_count_q + (ADDR_W + 1)'(1);
                    if (ld_last || wptr_q == WPTR_MAX) begin
                        state_d = S_RUN_IDLE;
                    end
                end
            end
            S_RUN_IDLE, S_RUN_RESP: begin
                // A reload request wins; a coincident fetch stays pending.
                if (ld_start) begin
                    state_d    = S_LOAD;
                    wptr_d     = '0;
                    ld_count_d = '0;
                end else if (cpu_req) begin
                    if (out_of_range) begin
                        cpu_instr_d = '0;
                        cpu_fault_d = 1'b1;
                        state_d     = S_RUN_RESP;
                    end else begin
                        state_d = S_RUN_WAIT;
                    end
                end else begin
                    state_d = S_RUN_IDLE;
                end
            end
            S_RUN_WAIT: begin
                cpu_instr_d = mem_rdata;
                cpu_fault_d = 1'b0;
                state_d     = S_RUN_RESP;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            wptr_q      <= '0;
            ld_count_q  <= '0;
            cpu_instr_q <= '0;
            cpu_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            ld_count_q  <= ld_count_d;
            cpu_instr_q <= cpu_instr_d;
            cpu_fault_q <= cpu_fault_d;
        end
    end

    assign cpu_ack   = (state_q == S_RUN_RESP);
    assign cpu_instr = cpu_instr_q;
    assign cpu_fault = cpu_fault_q;
    assign ld_count  = ld_count_q;

endmodule

// File: tb/tb_mips_imem_ctrl.sv
// Directed bench for mips_imem_ctrl with a synchronous-read memory model.
// Build with +define+IMEM_BOUND_CHECK_EN to exercise the bound-check variant.
module tb_mips_imem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [8:0]  ld_count;
    logic        loading;
    logic        cpu_req;
    logic [31:0] cpu_pc;
    logic        cpu_ack;
    logic [31:0] cpu_instr;
    logic        cpu_fault;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    mips_imem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_count  (ld_count),
        .loading   (loading),
        .cpu_req   (cpu_req),
        .cpu_pc    (cpu_pc),
        .cpu_ack   (cpu_ack),
        .cpu_instr (cpu_instr),
        .cpu_fault (cpu_fault),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous-read memory.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Hold a request until ack (bounded), check latency and response.
    task automatic fetch(input string tag, input logic [31:0] pc,
                         input logic [31:0] ei, input logic ef,
                         input int lat);
        int n;
        cpu_req = 1'b1;
        cpu_pc  = pc;
        n = 0;
        do begin
            step();
            n++;
        end while (!cpu_ack && n < 6);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_instr"}, 64'(cpu_instr), 64'(ei));
        chk({tag, "_fault"}, 64'(cpu_fault), 64'(ef));
        cpu_req = 1'b0;
        step();
    endtask

    task automatic load_word(input logic [31:0] d, input logic last,
                             input logic [7:0] addr);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        #1;
        chk("ld_we", 64'(mem_we), 64'd1);
        chk("ld_addr", 64'(mem_addr), 64'(addr));
        chk("ld_wdata", 64'(mem_wdata), 64'(d));
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h20080001;
        prog[1] = 32'h20090002;
        prog[2] = 32'h01095020;
        prog[3] = 32'hAC0A0000;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;
        mem_rdata = '0;
        reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b1;
        ld_data = 32'h12345678; ld_last = 1'b0;
        cpu_req = 1'b0; cpu_pc = '0;
        step(); step();
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        ld_valid = 1'b0;
        reset = 1'b0;
        step();
        chk("por_loading", 64'(loading), 64'd1);
        chk("por_ld_ready", 64'(ld_ready), 64'd1);
        chk("por_ld_count", 64'(ld_count), 64'd0);
        chk("por_ack", 64'(cpu_ack), 64'd0);
        chk("por_instr", 64'(cpu_instr), 64'd0);
        chk("por_fault", 64'(cpu_fault), 64'd0);

        // Boot load of four words; cpu_req must be ignored meanwhile.
        cpu_req = 1'b1; cpu_pc = 32'd2;
        for (int i = 0; i < 4; i++) begin
            load_word(prog[i], i == 3, 8'(i));
            chk("load_no_ack", 64'(cpu_ack), 64'd0);
        end
        cpu_req = 1'b0;
        chk("boot_loading", 64'(loading), 64'd0);
        chk("boot_ld_ready", 64'(ld_ready), 64'd0);
        chk("boot_count", 64'(ld_count), 64'd4);
        step();

        // In-range fetch, then held request for back-to-back acks.
        cpu_req = 1'b1; cpu_pc = 32'd2;
        step();
        chk("b2b_wait0", 64'(cpu_ack), 64'd0);
        step();
        chk("b2b_ack0", 64'(cpu_ack), 64'd1);
        chk("b2b_instr0", 64'(cpu_instr), 64'h01095020);
        chk("b2b_fault0", 64'(cpu_fault), 64'd0);
        step();
        chk("b2b_wait1", 64'(cpu_ack), 64'd0);
        step();
        chk("b2b_ack1", 64'(cpu_ack), 64'd1);
        cpu_req = 1'b0;
        step();
        chk("b2b_idle", 64'(cpu_ack), 64'd0);

        fetch("oob", 32'h100, 32'd0, 1'b1, 1);
        chk("hold_instr", 64'(cpu_instr), 64'd0);
        chk("hold_fault", 64'(cpu_fault), 64'd1);
        fetch("pc3", 32'd3, 32'hAC0A0000, 1'b0, 2);
        fetch("pc0", 32'd0, 32'h20080001, 1'b0, 2);
`ifdef IMEM_BOUND_CHECK_EN
        fetch("pc5", 32'd5, 32'd0, 1'b1, 1);
`else
        fetch("pc5", 32'd5, 32'hDEAD0005, 1'b0, 2);
`endif

        // Full 256-word load without ld_last.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("full_enter", 64'(loading), 64'd1);
        chk("full_clr", 64'(ld_count), 64'd0);
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h10000000 + i;
            if (i == 255) begin
                #1;
                chk("full_addr255", 64'(mem_addr), 64'd255);
            end
            step();
        end
        chk("full_count", 64'(ld_count), 64'd256);
        chk("full_exit", 64'(loading), 64'd0);
        chk("full_257_we", 64'(mem_we), 64'd0);
        step();
        ld_valid = 1'b0;
        chk("full_count_hold", 64'(ld_count), 64'd256);
        fetch("full_pc255", 32'd255, 32'h100000FF, 1'b0, 2);
        fetch("full_pc0", 32'd0, 32'h10000000, 1'b0, 2);

        // Reload wins over a coincident fetch, which is served afterwards.
        ld_start = 1'b1; cpu_req = 1'b1; cpu_pc = 32'd1;
        step();
        ld_start = 1'b0;
        chk("rl_loading", 64'(loading), 64'd1);
        chk("rl_count", 64'(ld_count), 64'd0);
        chk("rl_no_ack", 64'(cpu_ack), 64'd0);
        load_word(32'hAAAA0000, 1'b0, 8'd0);
        load_word(32'hBBBB0001, 1'b1, 8'd1);
        chk("rl_count2", 64'(ld_count), 64'd2);
        fetch("rl_pend", 32'd1, 32'hBBBB0001, 1'b0, 2);

        // Reset in the middle of a load.
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        load_word(32'hC0DE0000, 1'b0, 8'd0);
        load_word(32'hC0DE0001, 1'b0, 8'd1);
        reset = 1'b1; ld_valid = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(ld_ready), 64'd0);
        chk("mid_rst_we", 64'(mem_we), 64'd0);
        step();
        reset = 1'b0; ld_valid = 1'b0;
        chk("mid_rst_count", 64'(ld_count), 64'd0);
        chk("mid_rst_loading", 64'(loading), 64'd1);
        chk("mid_rst_instr", 64'(cpu_instr), 64'd0);
        load_word(32'hDDDD0000, 1'b1, 8'd0);
        chk("mid_rst_count1", 64'(ld_count), 64'd1);
        fetch("mid_rst_pc0", 32'd0, 32'hDDDD0000, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
